// File: rtl/axis_bram_capture.sv
// AXI4-Stream sink that captures one armed frame into a BRAM write port.
// Optional: define BRAM_CAPTURE_SYNC_EN to align capture to the next frame start.
module axis_bram_capture #(
    parameter int DATA_WIDTH = 24,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic                        arm,
    input  logic [ADDR_WIDTH-1:0]       depth,
    input  logic [DATA_WIDTH-1:0]       s_axis_tdata,
    input  logic                        s_axis_tvalid,
    input  logic                        s_axis_tlast,
    output logic                        s_axis_tready,
    output logic [DATA_WIDTH-1:0]       bram_wrdata,
    output logic [ADDR_WIDTH-1:0]       bram_addr,
    output logic [(DATA_WIDTH+7)/8-1:0] bram_we,
    output logic                        bram_en,
    output logic                        bram_clk,
    output logic                        busy,
    output logic                        done,
    output logic [ADDR_WIDTH:0]         beat_count
);

    localparam int WE_W = (DATA_WIDTH + 7) / 8;
    localparam logic [ADDR_WIDTH:0] CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_SOF,
        S_CAPTURE,
        S_DONE
    } state_t;

`ifdef BRAM_CAPTURE_SYNC_EN
    localparam state_t ARM_STATE = S_WAIT_SOF;
`else
    localparam state_t ARM_STATE = S_CAPTURE;
`endif

    state_t                 state_q, state_d;
    logic                   tready_q, tready_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   en_q, en_d;
    logic [WE_W-1:0]        we_q, we_d;
    logic [DATA_WIDTH-1:0]  wrdata_q, wrdata_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [ADDR_WIDTH:0]    count_q, count_d;
    logic [ADDR_WIDTH-1:0]  depth_q, depth_d;
    logic                   accept;
    logic                   final_beat;

    assign accept     = s_axis_tvalid & tready_q;
    assign final_beat = s_axis_tlast | (count_q == {1'b0, depth_q});

    // Next-state: arm restarts from anywhere, accepted beats fill BRAM
    always_comb begin
        state_d  = state_q;
        done_d   = done_q;
        en_d     = 1'b0;
        we_d     = '0;
        wrdata_d = wrdata_q;
        addr_d   = addr_q;
        count_d  = count_q;
        depth_d  = depth_q;
        if (arm) begin
            state_d = ARM_STATE;
            count_d = '0;
            done_d  = 1'b0;
            depth_d = depth;
        end else begin
            case (state_q)
`ifdef BRAM_CAPTURE_SYNC_EN
                S_WAIT_SOF: begin
                    if (accept && s_axis_tlast) begin
                        state_d = S_CAPTURE;
                    end
                end
`endif
                S_CAPTURE: begin
                    if (accept) begin
                        wrdata_d = s_axis_tdata;
                        addr_d   = count_q[ADDR_WIDTH-1:0];
                        we_d     = '1;
                        en_d     = 1'b1;
                        count_d  = count_q + CNT_ONE;
                        if (final_beat) begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
        tready_d = (state_d == S_WAIT_SOF) || (state_d == S_CAPTURE);
        busy_d   = tready_d;
    end

    // State and registered outputs
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q  <= S_IDLE;
            tready_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            en_q     <= 1'b0;
            we_q     <= '0;
            wrdata_q <= '0;
            addr_q   <= '0;
            count_q  <= '0;
            depth_q  <= '0;
        end else begin
            state_q  <= state_d;
            tready_q <= tready_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            en_q     <= en_d;
            we_q     <= we_d;
            wrdata_q <= wrdata_d;
            addr_q   <= addr_d;
            count_q  <= count_d;
            depth_q  <= depth_d;
        end
    end

    assign s_axis_tready = tready_q;
    assign bram_wrdata   = wrdata_q;
    assign bram_addr     = addr_q;
    assign bram_we       = we_q;
    assign bram_en       = en_q;
    assign bram_clk      = aclk;
    assign busy          = busy_q;
    assign done          = done_q;
    assign beat_count    = count_q;

endmodule

// File: tb/tb_axis_bram_capture.sv
// Self-checking bench for axis_bram_capture.
// Table frames, hand sequences and random frames against a simple model.
module tb_axis_bram_capture;

    localparam int DW = 24;
    localparam int AW = 12;

    logic          aclk;
    logic          aresetn;
    logic          arm;
    logic [AW-1:0] depth_i;
    logic [DW-1:0] tdata;
    logic          tvalid;
    logic          tlast;
    logic          tready;
    logic [DW-1:0] bram_wrdata;
    logic [AW-1:0] bram_addr;
    logic [2:0]    bram_we;
    logic          bram_en;
    logic          bram_clk;
    logic          busy;
    logic          done;
    logic [AW:0]   beat_count;

    axis_bram_capture #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .arm           (arm),
        .depth         (depth_i),
        .s_axis_tdata  (tdata),
        .s_axis_tvalid (tvalid),
        .s_axis_tlast  (tlast),
        .s_axis_tready (tready),
        .bram_wrdata   (bram_wrdata),
        .bram_addr     (bram_addr),
        .bram_we       (bram_we),
        .bram_en       (bram_en),
        .bram_clk      (bram_clk),
        .busy          (busy),
        .done          (done),
        .beat_count    (beat_count)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // BRAM behavioural model
    logic [DW-1:0] mem [0:(1<<AW)-1];
    int unsigned   wr_total = 0;
    always @(posedge bram_clk) begin
        if (bram_en && bram_we == 3'b111) begin
            mem[bram_addr] <= bram_wrdata;
            wr_total       <= wr_total + 1;
        end
    end

    int  n_vec = 0;
    int  n_bad = 0;
    bit  gaps  = 0;

    typedef struct {
        int d;
        int n;
        bit lst;
        int en;
        bit ed;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] dval(int base, int step, int i);
        int v;
        v = base + i * step;
        return v[DW-1:0];
    endfunction

    // All tasks enter and leave at a falling edge
    task automatic arm_only(input int d);
        arm     = 1'b1;
        depth_i = d[AW-1:0];
        @(negedge aclk);
        arm     = 1'b0;
    endtask

    task automatic beat(input logic [DW-1:0] d, input bit l, output bit acc);
        bit rdy;
        acc = 0;
        if (gaps) begin
            repeat ($urandom_range(0, 2)) @(negedge aclk);
        end
        tvalid = 1'b1;
        tdata  = d;
        tlast  = l;
        for (int c = 0; c < 8; c++) begin
            rdy = tready;
            @(negedge aclk);
            if (rdy) begin
                acc = 1;
                break;
            end
        end
        tvalid = 1'b0;
        tlast  = 1'b0;
    endtask

    task automatic do_arm(input int d);
        bit a;
        arm_only(d);
`ifdef BRAM_CAPTURE_SYNC_EN
        beat(24'hDEAD00, 1'b1, a);
`else
        a = 1;
`endif
    endtask

    task automatic run_frame(input string nm, input int d, input int n,
                             input bit lst, input int base, input int step,
                             input int exp_n, input bit exp_done);
        int unsigned w0;
        int          acc_cnt;
        bit          a;
        do_arm(d);
        w0      = wr_total;
        acc_cnt = 0;
        for (int i = 0; i < n; i++) begin
            beat(dval(base, step, i), lst && (i == n - 1), a);
            if (!a) break;
            acc_cnt++;
            if (exp_done && acc_cnt == exp_n) begin
                chk({nm, " done_at_last_write"}, {31'd0, done}, 1);
                chk({nm, " we_at_last_write"}, {29'd0, bram_we}, 7);
                chk({nm, " addr_last"}, {20'd0, bram_addr}, exp_n - 1);
                chk({nm, " data_last"}, {8'd0, bram_wrdata},
                    {8'd0, dval(base, step, exp_n - 1)});
                chk({nm, " tready_drop"}, {31'd0, tready}, 0);
            end
        end
        @(negedge aclk);
        chk({nm, " accepted"}, acc_cnt, exp_n);
        chk({nm, " beat_count"}, {19'd0, beat_count}, exp_n);
        chk({nm, " done"}, {31'd0, done}, {31'd0, exp_done});
        chk({nm, " tready"}, {31'd0, tready}, {31'd0, !exp_done});
        chk({nm, " writes"}, wr_total - w0, exp_n);
        for (int j = 0; j < exp_n; j++) begin
            chk({nm, " mem"}, {8'd0, mem[j]}, {8'd0, dval(base, step, j)});
        end
    endtask

    initial begin
        bit          a;
        int unsigned w0;
        arm     = 1'b0;
        depth_i = '0;
        tdata   = '0;
        tvalid  = 1'b0;
        tlast   = 1'b0;
        aresetn = 1'b0;

        tbl[0] = '{d: 7,  n: 4,  lst: 1, en: 4, ed: 1};
        tbl[1] = '{d: 3,  n: 10, lst: 0, en: 4, ed: 1};
        tbl[2] = '{d: 0,  n: 3,  lst: 0, en: 1, ed: 1};
        tbl[3] = '{d: 5,  n: 6,  lst: 1, en: 6, ed: 1};
        tbl[4] = '{d: 10, n: 1,  lst: 1, en: 1, ed: 1};
        tbl[5] = '{d: 9,  n: 4,  lst: 0, en: 4, ed: 0};

        repeat (3) @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
        chk("rst tready", {31'd0, tready}, 0);
        chk("rst we", {29'd0, bram_we}, 0);
        chk("rst en", {31'd0, bram_en}, 0);
        chk("rst busy", {31'd0, busy}, 0);
        chk("rst done", {31'd0, done}, 0);
        chk("rst addr", {20'd0, bram_addr}, 0);
        chk("rst wrdata", {8'd0, bram_wrdata}, 0);
        chk("rst count", {19'd0, beat_count}, 0);

        for (int k = 0; k < 6; k++) begin
            run_frame($sformatf("tbl%0d", k), tbl[k].d, tbl[k].n, tbl[k].lst,
                      16 + 256 * k, 1, tbl[k].en, tbl[k].ed);
        end

`ifdef BRAM_CAPTURE_SYNC_EN
        // Arm mid-frame: tail of the running frame is discarded
        arm_only(7);
        w0 = wr_total;
        beat(24'h000111, 1'b0, a);
        beat(24'h000112, 1'b1, a);
        beat(24'h0000A0, 1'b0, a);
        beat(24'h0000A1, 1'b0, a);
        beat(24'h0000A2, 1'b1, a);
        @(negedge aclk);
        chk("sof writes", wr_total - w0, 3);
        chk("sof mem0", {8'd0, mem[0]}, 32'hA0);
        chk("sof mem1", {8'd0, mem[1]}, 32'hA1);
        chk("sof mem2", {8'd0, mem[2]}, 32'hA2);
        chk("sof count", {19'd0, beat_count}, 3);
`endif

        // Re-arm mid-capture with a beat offered in the arm cycle
        do_arm(20);
        for (int i = 0; i < 5; i++) beat(24'h300 + i[DW-1:0], 1'b0, a);
        @(negedge aclk);
        chk("rearm pre count", {19'd0, beat_count}, 5);
        w0      = wr_total;
        arm     = 1'b1;
        depth_i = 12'd20;
        tvalid  = 1'b1;
        tdata   = 24'h000BAD;
        @(negedge aclk);
        arm     = 1'b0;
        tvalid  = 1'b0;
        chk("rearm count", {19'd0, beat_count}, 0);
        chk("rearm done", {31'd0, done}, 0);
        chk("rearm we", {29'd0, bram_we}, 0);
`ifdef BRAM_CAPTURE_SYNC_EN
        beat(24'hDEAD01, 1'b1, a);
`endif
        beat(24'h000055, 1'b0, a);
        @(negedge aclk);
        chk("rearm mem0", {8'd0, mem[0]}, 32'h55);
        chk("rearm writes", wr_total - w0, 1);
        chk("rearm count1", {19'd0, beat_count}, 1);
        chk("rearm done1", {31'd0, done}, 0);

        // Reset while capturing
        do_arm(50);
        for (int i = 0; i < 3; i++) beat(24'h700 + i[DW-1:0], 1'b0, a);
        @(negedge aclk);
        aresetn = 1'b0;
        #1;
        chk("mrst tready", {31'd0, tready}, 0);
        chk("mrst we", {29'd0, bram_we}, 0);
        chk("mrst en", {31'd0, bram_en}, 0);
        chk("mrst busy", {31'd0, busy}, 0);
        chk("mrst done", {31'd0, done}, 0);
        chk("mrst addr", {20'd0, bram_addr}, 0);
        chk("mrst wrdata", {8'd0, bram_wrdata}, 0);
        chk("mrst count", {19'd0, beat_count}, 0);
        @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
        @(negedge aclk);
        chk("post rst tready", {31'd0, tready}, 0);
        chk("post rst busy", {31'd0, busy}, 0);
        chk("post rst mem kept", {8'd0, mem[2]}, 32'h702);

        // Full 256-beat ramp with random valid gaps
        gaps = 1;
        run_frame("ramp", 255, 256, 1'b1, 0, 1, 256, 1'b1);

        // Random frames: model keeps min(n, depth+1) beats
        for (int t = 0; t < 20; t++) begin
            int d, n, en;
            bit l, ed;
            d  = $urandom_range(0, 31);
            n  = $urandom_range(1, 40);
            l  = 1'($urandom_range(0, 1));
            en = (n < d + 1) ? n : d + 1;
            ed = l || (n >= d + 1);
            run_frame($sformatf("rnd%0d", t), d, n, l,
                      int'($urandom_range(0, 24'hFFFFFF)), 37, en, ed);
        end
        gaps = 0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
